// File: rtl/stream_demux_1_to_2.sv
// stream_demux_1_to_2
// Routes each input beat to out0 or out1 according to in_sel. Each output
// has its own 2-entry FIFO, so a stalled consumer only blocks beats headed
// to it. Per-port saturating counters track delivered beats.
module stream_demux_1_to_2 #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [CNT_WIDTH-1:0]  cnt0,
  output logic [CNT_WIDTH-1:0]  cnt1
);

  logic [1:0]            port_ready;
  logic [1:0]            port_valid;
  logic [1:0]            port_full;
  logic [DATA_WIDTH-1:0] port_data [2];
  logic [CNT_WIDTH-1:0]  port_cnt  [2];

  assign port_ready = {out1_ready, out0_ready};

  // Accept depends only on the selected FIFO's registered full flag, so
  // out*_ready never reaches in_ready combinationally.
  assign in_ready = rst_n & ~port_full[in_sel];

  genvar g;
  for (g = 0; g < 2; g++) begin : g_port
    logic [DATA_WIDTH-1:0] mem0;
    logic [DATA_WIDTH-1:0] mem1;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  push;
    logic                  pop;

    assign push = in_valid & in_ready & (in_sel == 1'(g));
    assign pop  = (occ != 2'd0) & port_ready[g];

    // FIFO storage, pointers and occupancy; reset clears storage so the
    // outputs read zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem0   <= '0;
        mem1   <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        occ    <= 2'd0;
      end else begin
        if (push) begin
          if (wr_ptr) mem1 <= in_data;
          else        mem0 <= in_data;
          wr_ptr <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end

    // Delivered-beat counter, holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt <= '0;
      else if (pop && cnt != '1)  cnt <= cnt + 1'b1;
    end

    assign port_valid[g] = (occ != 2'd0);
    assign port_full[g]  = (occ == 2'd2);
    assign port_data[g]  = rd_ptr ? mem1 : mem0;
    assign port_cnt[g]   = cnt;
  end

  assign out0_data  = port_data[0];
  assign out1_data  = port_data[1];
  assign out0_valid = port_valid[0];
  assign out1_valid = port_valid[1];
  assign cnt0       = port_cnt[0];
  assign cnt1       = port_cnt[1];

endmodule

// File: tb/tb_stream_demux_1_to_2.sv
// Bench for stream_demux_1_to_2: per-port scoreboards fed on acceptance and
// drained on output handshakes, plus directed per-scenario checks.
module tb_stream_demux_1_to_2;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out0_data, out1_data;
  logic          out0_valid, out1_valid;
  logic          out0_ready = 1'b0;
  logic          out1_ready = 1'b0;
  logic [CW-1:0] cnt0, cnt1;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  stream_demux_1_to_2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: at negedge, pops are compared before the same cycle's push is
  // recorded (a pushed beat can never leave in its own cycle).
  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        total++;
        if (q0.size() == 0) begin
          bad++; $display("FAIL sb_out0: got %h, expected nothing", out0_data);
        end else begin
          logic [DW-1:0] e;
          e = q0.pop_front();
          if (out0_data !== e) begin
            bad++; $display("FAIL sb_out0: got %h, expected %h", out0_data, e);
          end
        end
      end
      if (out1_valid && out1_ready) begin
        total++;
        if (q1.size() == 0) begin
          bad++; $display("FAIL sb_out1: got %h, expected nothing", out1_data);
        end else begin
          logic [DW-1:0] e;
          e = q1.pop_front();
          if (out1_data !== e) begin
            bad++; $display("FAIL sb_out1: got %h, expected %h", out1_data, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
    q0.delete(); q1.delete();
    step();
    total++;
    if (in_ready !== 1'b0 || out0_valid !== 1'b0 || out1_valid !== 1'b0 ||
        out0_data !== '0 || out1_data !== '0 || cnt0 !== '0 || cnt1 !== '0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b v0=%b v1=%b d0=%h d1=%h c0=%0d c1=%0d, expected all 0",
               in_ready, out0_valid, out1_valid, out0_data, out1_data, cnt0, cnt1);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA5A5_0001;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_in_ready: got %b, expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 32'hA5A5_0001 || out1_valid !== 1'b0 || cnt0 !== 4'd0) begin
      bad++;
      $display("FAIL basic_out: v0=%b d0=%h v1=%b c0=%0d, expected 1 a5a50001 0 0",
               out0_valid, out0_data, out1_valid, cnt0);
    end
    step();
    total++;
    if (cnt0 !== 4'd1 || out0_valid !== 1'b0) begin
      bad++; $display("FAIL basic_cnt: c0=%0d v0=%b, expected 1 0", cnt0, out0_valid);
    end
    out0_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out1_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h11;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_acc11: got %b, expected 1", in_ready); end
    step();
    in_data = 32'h22;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_acc22: got %b, expected 1", in_ready); end
    step();
    in_data = 32'h33;
    total++;
    if (in_ready !== 1'b0 || out1_data !== 32'h11) begin
      bad++; $display("FAIL bp_full: rdy=%b d1=%h, expected 0 11", in_ready, out1_data);
    end
    step();
    out1_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_pop_same_cycle: got %b, expected 0", in_ready);
    end
    step();
    out1_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_acc33: got %b, expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (out1_valid !== 1'b0 || q1.size() != 0 || cnt1 !== 4'd3) begin
      bad++; $display("FAIL bp_drain: v1=%b left=%0d c1=%0d, expected 0 0 3", out1_valid, q1.size(), cnt1);
    end
    out1_ready = 1'b0;
  endtask

  task automatic test_isolation();
    do_reset();
    out1_ready = 1'b0; out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h77; step();
    in_data = 32'h88; step();
    in_sel = 1'b0; in_data = 32'h44;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL iso_ready: got %b, expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 32'h44 || out1_valid !== 1'b1 || out1_data !== 32'h77) begin
      bad++;
      $display("FAIL iso_out: v0=%b d0=%h v1=%b d1=%h, expected 1 44 1 77",
               out0_valid, out0_data, out1_valid, out1_data);
    end
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++; $display("FAIL iso_drain: left0=%0d left1=%0d, expected 0 0", q0.size(), q1.size());
    end
    out0_ready = 1'b0; out1_ready = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h55; step();
    in_data = 32'h66; out0_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out0_data !== 32'h55) begin
      bad++; $display("FAIL simul_pre: rdy=%b d0=%h, expected 1 55", in_ready, out0_data);
    end
    step();
    in_valid = 1'b0; out0_ready = 1'b0;
    total++;
    if (out0_valid !== 1'b1 || out0_data !== 32'h66) begin
      bad++; $display("FAIL simul_head: v0=%b d0=%h, expected 1 66", out0_valid, out0_data);
    end
    out0_ready = 1'b1; step(); out0_ready = 1'b0;
    total++;
    if (out0_valid !== 1'b0) begin
      bad++; $display("FAIL simul_occ1: v0=%b after one pop, expected 0", out0_valid);
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    do_reset();
    out0_ready = 1'b1; out1_ready = 1'b1; in_valid = 1'b1;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      in_sel = i[0]; in_data = 32'h100 + i;
      #1;
      if (in_ready !== 1'b1) stalls++;
      step();
    end
    in_valid = 1'b0;
    total++;
    if (stalls != 0) begin bad++; $display("FAIL b2b_throughput: stalls=%0d, expected 0", stalls); end
    step(); step();
    total++;
    if (cnt0 !== 4'd10 || cnt1 !== 4'd10) begin
      bad++; $display("FAIL b2b_cnt: c0=%0d c1=%0d, expected 10 10", cnt0, cnt1);
    end
    do_reset();
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h200 + i;
      step();
    end
    in_valid = 1'b0;
    step(); step();
    total++;
    if (cnt0 !== 4'd15 || cnt1 !== 4'd0) begin
      bad++; $display("FAIL cnt_saturate: c0=%0d c1=%0d, expected 15 0", cnt0, cnt1);
    end
  endtask

  task automatic test_reset_mid();
    out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
    in_sel = 1'b0; in_data = 32'h301; step();
    in_data = 32'h302; step();
    in_sel = 1'b1; in_data = 32'h311; step();
    in_data = 32'h312; step();
    in_valid = 1'b0;
    total++;
    if (out0_valid !== 1'b1 || out1_valid !== 1'b1 || cnt0 !== 4'd15) begin
      bad++; $display("FAIL mid_prefill: v0=%b v1=%b c0=%0d, expected 1 1 15", out0_valid, out1_valid, cnt0);
    end
    #2 rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    total++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || cnt0 !== '0 || cnt1 !== '0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async: v0=%b v1=%b c0=%0d c1=%0d rdy=%b, expected all 0",
               out0_valid, out1_valid, cnt0, cnt1, in_ready);
    end
    step();
    rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    begin
      int stale;
      stale = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) stale++;
      end
      total++;
      if (stale != 0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL mid_after_release: stale=%0d rdy=%b, expected 0 1", stale, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_isolation();
    test_simul_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_to_2.md
Name: stream_demux_1_to_2

Overview:
- Steers one valid/ready data stream to one of two output streams, selected per transaction by in_sel.
- Counterpart of the 2:1 select mux. Used wherever one producer feeds two consumers, e.g. splitting a result stream between writeback and a side unit.
- Each output has a 2-entry FIFO. A stalled consumer therefore back-pressures only transactions aimed at it.
- Per-output transaction counters are provided for debug and performance monitoring.

Parameters:
- DATA_WIDTH, 32, width of the data payload on the input and both outputs.
- CNT_WIDTH, 16, width of each per-output delivered-transaction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_WIDTH  input payload.
- in_sel  input  1  destination of the current input beat: 0 = out0, 1 = out1.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- out0_data  output  DATA_WIDTH  head-of-FIFO payload, port 0.
- out0_valid  output  1  port 0 FIFO non-empty.
- out0_ready  input  1  port 0 consumer accepts.
- out1_data  output  DATA_WIDTH  head-of-FIFO payload, port 1.
- out1_valid  output  1  port 1 FIFO non-empty.
- out1_ready  input  1  port 1 consumer accepts.
- cnt0  output  CNT_WIDTH  beats delivered on port 0 (saturating).
- cnt1  output  CNT_WIDTH  beats delivered on port 1 (saturating).

Behaviour:
- Reset:
  - Asynchronous assert on rst_n low; synchronous release.
  - While rst_n is low: both FIFOs are empty, out*_valid = 0, out*_data = 0, cnt0 = cnt1 = 0, in_ready = 0.
  - Reset asserted mid-operation discards all buffered beats immediately. No partial output.
- FIFO, per port:
  - Depth 2. Write pointer, read pointer and a 2-bit occupancy count (0..2). Pointers wrap modulo 2.
  - outN_data is driven from the storage entry at the read pointer. It holds stable while outN_valid && !outN_ready.
- Accept:
  - in_ready = !full[in_sel], with rst_n high.
  - Depends combinationally on in_sel only. There is no combinational path from out*_ready to in_ready.
  - A full target FIFO blocks the input even if its consumer pops in the same cycle. It accepts on the next cycle.
  - in_sel and in_data are ignored when in_valid = 0.
- Push: on in_valid && in_ready, in_data is written to FIFO[in_sel].
- Pop: on outN_valid && outN_ready, the FIFO N read pointer advances.
- Latency: a beat accepted at edge k appears on outN_valid/outN_data after edge k, i.e. 1 cycle. No same-cycle bypass.
- Simultaneous push and pop on the same FIFO:
  - Occupancy 1: occupancy stays 1. The popped beat is the old head; the pushed beat becomes the new head.
  - Occupancy 0: a pop cannot occur (valid = 0); the push proceeds.
  - Occupancy 2: the push cannot occur.
- Ordering:
  - Beats to the same port leave in acceptance order.
  - There is no ordering guarantee between ports.
  - A stall on one port never blocks beats to the other port whose FIFO has space.
- Counters:
  - cntN increments by 1 on each outN handshake.
  - It saturates at 2^CNT_WIDTH-1 and never wraps.
  - Counters are cleared only by reset.
- No combinational path from in_* to out*. All out* signals and cnt* come from registers.

Test Plan:
- Reset, then in_valid=1, in_sel=0, in_data=0xA5A5_0001, out0_ready=1 -> in_ready=1; the next cycle out0_valid=1 with out0_data=0xA5A5_0001; out1_valid stays 0; cnt0 becomes 1 after the handshake.
- out1_ready=0; push 0x11, 0x22, 0x33 with in_sel=1 -> first two accepted. For 0x33, in_ready=0 while full; 0x33 is accepted the cycle after out1_ready pulses. Output order is 0x11, 0x22, 0x33.
- Port 1 full and stalled; present in_sel=0, data 0x44 -> in_ready=1; 0x44 is delivered on out0 the following cycle; port 1 contents are unchanged.
- Occupancy 1 on port 0 (head 0x55); same cycle push 0x66 to port 0 and out0_ready=1 -> 0x55 is popped; next cycle out0_data=0x66, occupancy 1.
- Continuous back-to-back alternating in_sel with both readies high for 20 beats -> one beat per cycle throughput; cnt0=10, cnt1=10. With CNT_WIDTH=4 and 20 beats to port 0, cnt0 saturates at 15.
- Deassert rst_n mid-stream with both FIFOs holding 2 beats -> out0_valid, out1_valid, cnt0, cnt1 are 0 and in_ready=0 with no clock edge. After release, in_ready=1 and no stale beats are delivered.
